famiclone_probe: RTL

Power-up console-type detector for the cartridge PPU side. It is a parametrised successor of the fixed 4-bit-init / 2-sample "new Dendy" detection. It holds CIRAM /CE and /A13 low for a configurable number of M2 cycles while the console powers up. It then samples PPU reads and counts how often the console's /A13 line disagrees with the inverse of PA13. It classifies the console as standard or new-style famiclone, with a confidence threshold, a timeout and software re-arm. The mapper top uses its outputs to mux `ppu_ciram_ce` and `ppu_not_a13_out`.

---
 rtl/famiclone_probe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/famiclone_probe.sv
// Power-up console-type detector: holds CIRAM pins low after reset, then samples
// PPU reads to tell a standard console from a new-style famiclone by its /A13 behaviour.
module famiclone_probe #(
  parameter int INIT_CYCLES        = 15,
  parameter int SAMPLE_COUNT       = 3,
  parameter int MISMATCH_THRESHOLD = 1,
  parameter int TIMEOUT_CYCLES     = 65535
) (
  input  logic       m2,
  input  logic       rst_n,
  input  logic       ppu_rd_in,
  input  logic       ppu_a13,
  input  logic       ppu_not_a13,
  input  logic       redetect,
  output logic       force_low,
  output logic       detect_done,
  output logic       new_dendy,
  output logic       timed_out,
  output logic [7:0] mismatch_cnt
);

  localparam int              HOLD_W = $clog2(INIT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(INIT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [7:0]      SC8    = 8'(SAMPLE_COUNT);
  localparam logic [8:0]      THR9   = 9'(MISMATCH_THRESHOLD);
  localparam logic [23:0]     TMO24  = 24'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_SAMPLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        mis_d;
  logic [23:0]       tmo_q, tmo_d;
  logic              force_d, done_d, nd_d, to_d;

  logic              take_lo, take_hi, miss;
  logic [7:0]        lo_n, hi_n, mis_n;
  logic [23:0]       tmo_n;
  logic              verdict, tmo_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic meets_thr(input logic [7:0] v);
    return {1'b0, v} >= THR9;
  endfunction

  // Sample qualification: a class that already holds SAMPLE_COUNT reads discards further ones
  always_comb begin
    take_lo = ~ppu_rd_in & ~ppu_a13 & (lo_q < SC8);
    take_hi = ~ppu_rd_in &  ppu_a13 & (hi_q < SC8);
    miss    = (take_lo | take_hi) & (ppu_not_a13 == ppu_a13);
    lo_n    = lo_q + {7'd0, take_lo};
    hi_n    = hi_q + {7'd0, take_hi};
    mis_n   = miss ? sat_inc8(mismatch_cnt) : mismatch_cnt;
    tmo_n   = tmo_q + 24'd1;
    verdict = (lo_n == SC8) & (hi_n == SC8);
    tmo_hit = (tmo_n == TMO24);
  end

  always_ff @(posedge m2) begin
    if (!rst_n) state_q <= S_HOLD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD:   if (hold_q == HOLD_ONE)   state_d = S_SAMPLE;
      S_SAMPLE: if (verdict || tmo_hit)   state_d = S_DONE;
      S_DONE:   if (redetect)             state_d = S_SAMPLE;
      default:                            state_d = S_HOLD;
    endcase
  end

  always_comb begin
    hold_d  = hold_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mis_d   = mismatch_cnt;
    tmo_d   = tmo_q;
    force_d = force_low;
    done_d  = detect_done;
    nd_d    = new_dendy;
    to_d    = timed_out;
    case (state_q)
      S_HOLD: begin
        hold_d = hold_q - HOLD_ONE;
        if (hold_q == HOLD_ONE) force_d = 1'b0;
      end
      S_SAMPLE: begin
        lo_d  = lo_n;
        hi_d  = hi_n;
        mis_d = mis_n;
        tmo_d = tmo_n;
        // A full sample set on the timeout edge is a genuine verdict, not a timeout
        if (verdict) begin
          done_d = 1'b1;
          nd_d   = meets_thr(mis_n);
          to_d   = 1'b0;
        end else if (tmo_hit) begin
          done_d = 1'b1;
          nd_d   = meets_thr(mis_n);
          to_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (redetect) begin
          lo_d   = 8'd0;
          hi_d   = 8'd0;
          mis_d  = 8'd0;
          tmo_d  = 24'd0;
          done_d = 1'b0;
          nd_d   = 1'b0;
          to_d   = 1'b0;
        end
      end
      default: begin
        force_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge m2) begin
    if (!rst_n) begin
      hold_q       <= HOLD_INIT;
      lo_q         <= 8'd0;
      hi_q         <= 8'd0;
      tmo_q        <= 24'd0;
      mismatch_cnt <= 8'd0;
      force_low    <= 1'b1;
      detect_done  <= 1'b0;
      new_dendy    <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      tmo_q        <= tmo_d;
      mismatch_cnt <= mis_d;
      force_low    <= force_d;
      detect_done  <= done_d;
      new_dendy    <= nd_d;
      timed_out    <= to_d;
    end
  end

endmodule
